// File: rtl/capture_pkg.sv
// Shared timing defaults and FSM state encoding for the video capture path
// and the VGA output side.
package capture_pkg;

   localparam int H_PIXELS_DEF       = 512;
   localparam int V_LINES_DEF        = 384;
   localparam int V_OFFSET_DEF       = 16;
   localparam int H_OFFSET_DEF       = 40;
   localparam int CLKS_PER_PIXEL_DEF = 4;
   localparam int LINE_TIMEOUT_DEF   = 4096;
   localparam int ADDR_WIDTH_DEF     = 18;

   typedef logic [2:0] cap_state_t;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_VSYNC = 3'd1;
   localparam logic [2:0] ST_WAIT_HSYNC = 3'd2;
   localparam logic [2:0] ST_H_PORCH    = 3'd3;
   localparam logic [2:0] ST_SAMPLE     = 3'd4;

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge detector; the history register resets high so a level held
// high across reset is not mistaken for an edge.
module sync_edge_detect (
   input  logic clk_i,
   input  logic srst_i,
   input  logic sig_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (srst_i) prev_q <= 1'b1;
      else        prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/capture_controller.sv
// Locks onto HP mono video frame/line timing, skips porches and writes one
// frame-buffer word per pixel sampled at mid-pixel.
module capture_controller
   import capture_pkg::*;
#(
   parameter int H_PIXELS       = H_PIXELS_DEF,
   parameter int V_LINES        = V_LINES_DEF,
   parameter int V_OFFSET       = V_OFFSET_DEF,
   parameter int H_OFFSET       = H_OFFSET_DEF,
   parameter int CLKS_PER_PIXEL = CLKS_PER_PIXEL_DEF,
   parameter int LINE_TIMEOUT   = LINE_TIMEOUT_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ENABLE,
   input  logic                  HSYNC_IN,
   input  logic                  VSYNC_IN,
   input  logic                  VIDEO_IN,
   output logic                  WR_EN,
   output logic [ADDR_WIDTH-1:0] WR_ADDR,
   output logic                  WR_DATA,
   output logic                  FRAME_DONE,
   output logic                  LOCKED,
   output logic                  SYNC_ERR
);

   localparam int PX_W   = $clog2(H_PIXELS + 2);
   localparam int ROW_W  = $clog2(V_LINES + 2);
   localparam int LINE_W = $clog2(V_OFFSET + 2);
   localparam int CLK_W  = $clog2(H_OFFSET + 2);
   localparam int PH_W   = $clog2(CLKS_PER_PIXEL + 2);
   localparam int TO_W   = $clog2(LINE_TIMEOUT + 2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(H_PIXELS * V_LINES - 1);

   logic hs_rise, vs_rise;

   sync_edge_detect u_hs_edge (.clk_i(CLK), .srst_i(RESET), .sig_i(HSYNC_IN), .rise_o(hs_rise));
   sync_edge_detect u_vs_edge (.clk_i(CLK), .srst_i(RESET), .sig_i(VSYNC_IN), .rise_o(vs_rise));

   cap_state_t              state_q, state_d;
   logic [LINE_W-1:0]       line_cnt_q, line_cnt_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [PX_W-1:0]         px_q, px_d;
   logic [CLK_W-1:0]        clk_cnt_q, clk_cnt_d;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    wr_en_q, wr_en_d;
   logic                    wr_data_q, wr_data_d;
   logic                    frame_done_q, frame_done_d;
   logic                    locked_q, locked_d;
   logic                    sync_err_q, sync_err_d;
   logic                    err, clear_cnt;

   always_comb begin
      state_d      = state_q;
      line_cnt_d   = line_cnt_q;
      row_d        = row_q;
      px_d         = px_q;
      clk_cnt_d    = clk_cnt_q;
      phase_d      = phase_q;
      to_d         = to_q;
      addr_d       = addr_q;
      wr_en_d      = 1'b0;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      locked_d     = locked_q;
      sync_err_d   = 1'b0;
      err          = 1'b0;
      clear_cnt    = 1'b0;

      if (!ENABLE) begin
         state_d   = ST_IDLE;
         locked_d  = 1'b0;
         clear_cnt = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_WAIT_VSYNC;
            ST_WAIT_VSYNC: begin
               if (vs_rise) begin
                  state_d   = ST_WAIT_HSYNC;
                  clear_cnt = 1'b1;
               end
            end
            ST_WAIT_HSYNC: begin
               if (vs_rise) begin
                  err = 1'b1;
               end else if (hs_rise) begin
                  if (line_cnt_q < LINE_W'(V_OFFSET)) begin
                     line_cnt_d = line_cnt_q + LINE_W'(1);
                  end else begin
                     state_d   = ST_H_PORCH;
                     clk_cnt_d = '0;
                  end
               end else if (row_q != '0) begin
                  // The line timeout only guards gaps between active lines.
                  if (to_q == TO_W'(LINE_TIMEOUT - 1)) err = 1'b1;
                  else                                  to_d = to_q + TO_W'(1);
               end
            end
            ST_H_PORCH: begin
               if (vs_rise || hs_rise) begin
                  err = 1'b1;
               end else if (clk_cnt_q == CLK_W'(H_OFFSET - 1)) begin
                  state_d = ST_SAMPLE;
                  phase_d = '0;
                  px_d    = '0;
               end else begin
                  clk_cnt_d = clk_cnt_q + CLK_W'(1);
               end
            end
            ST_SAMPLE: begin
               if (vs_rise || hs_rise) begin
                  err = 1'b1;
               end else begin
                  phase_d = (phase_q == PH_W'(CLKS_PER_PIXEL - 1)) ? '0 : phase_q + PH_W'(1);
                  if (phase_q == PH_W'(CLKS_PER_PIXEL / 2)) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = VIDEO_IN;
                  end
                  // Bookkeeping follows the write strobe currently on the bus.
                  if (wr_en_q) begin
                     addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_WIDTH'(1);
                     if (px_q == PX_W'(H_PIXELS - 1)) begin
                        if (row_q == ROW_W'(V_LINES - 1)) begin
                           frame_done_d = 1'b1;
                           locked_d     = 1'b1;
                           state_d      = ST_WAIT_VSYNC;
                        end else begin
                           row_d   = row_q + ROW_W'(1);
                           to_d    = '0;
                           state_d = ST_WAIT_HSYNC;
                        end
                     end else begin
                        px_d = px_q + PX_W'(1);
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (err) begin
         sync_err_d = 1'b1;
         locked_d   = 1'b0;
         state_d    = ST_WAIT_VSYNC;
         clear_cnt  = 1'b1;
      end

      if (clear_cnt) begin
         line_cnt_d = '0;
         row_d      = '0;
         px_d       = '0;
         clk_cnt_d  = '0;
         phase_d    = '0;
         to_d       = '0;
         addr_d     = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         line_cnt_q   <= '0;
         row_q        <= '0;
         px_q         <= '0;
         clk_cnt_q    <= '0;
         phase_q      <= '0;
         to_q         <= '0;
         addr_q       <= '0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= 1'b0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_cnt_q   <= line_cnt_d;
         row_q        <= row_d;
         px_q         <= px_d;
         clk_cnt_q    <= clk_cnt_d;
         phase_q      <= phase_d;
         to_q         <= to_d;
         addr_q       <= addr_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         locked_q     <= locked_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign WR_EN      = wr_en_q;
   assign WR_ADDR    = addr_q;
   assign WR_DATA    = wr_data_q;
   assign FRAME_DONE = frame_done_q;
   assign LOCKED     = locked_q;
   assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller using a reduced frame geometry
// (16x6 pixels) with the default horizontal offset and pixel clocking.
module tb_capture_controller;

   localparam int H_PIX    = 16;
   localparam int V_LIN    = 6;
   localparam int V_OFF    = 3;
   localparam int H_OFF    = 40;
   localparam int CPP      = 4;
   localparam int TIMEOUT  = 200;
   localparam int AW       = 7;
   // Hand-derived offsets from the HSYNC edge cycle t: 40 + 1 + 2 + 1 = 44.
   localparam int FIRST_WR = 44;
   localparam int FD_OFF   = 105;
   localparam int AB_NONE = 0, AB_VSYNC = 1, AB_ENABLE = 2, AB_RESET = 3;

   logic          CLK = 1'b0;
   logic          RESET, ENABLE, HSYNC_IN, VSYNC_IN, VIDEO_IN;
   logic          WR_EN, WR_DATA, FRAME_DONE, LOCKED, SYNC_ERR;
   logic [AW-1:0] WR_ADDR;

   capture_controller #(
      .H_PIXELS(H_PIX), .V_LINES(V_LIN), .V_OFFSET(V_OFF), .H_OFFSET(H_OFF),
      .CLKS_PER_PIXEL(CPP), .LINE_TIMEOUT(TIMEOUT), .ADDR_WIDTH(AW)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .HSYNC_IN(HSYNC_IN),
      .VSYNC_IN(VSYNC_IN), .VIDEO_IN(VIDEO_IN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
      .WR_DATA(WR_DATA), .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_fd[$];
   int  exp_err[$];
   int  n_checks = 0;
   int  n_pass = 0;

   function automatic void check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
   endfunction

   // Monitor: pop and compare whenever the DUT presents an event.
   wr_t mon_w;
   int  mon_c;
   always @(negedge CLK) begin
      if (WR_EN) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_wr_en", 1, 0);
         end else begin
            mon_w = exp_wr.pop_front();
            check("wr_cycle", cyc, mon_w.cyc);
            check("wr_addr", int'(WR_ADDR), mon_w.addr);
            check("wr_data", int'(WR_DATA), mon_w.data);
            $display("wr   cyc=%0d addr=%0d data=%0d", cyc, WR_ADDR, WR_DATA);
         end
      end
      if (FRAME_DONE) begin
         if (exp_fd.size() == 0) check("unexpected_frame_done", 1, 0);
         else begin
            mon_c = exp_fd.pop_front();
            check("frame_done_cycle", cyc, mon_c);
            $display("done cyc=%0d", cyc);
         end
      end
      if (SYNC_ERR) begin
         if (exp_err.size() == 0) check("unexpected_sync_err", 1, 0);
         else begin
            mon_c = exp_err.pop_front();
            check("sync_err_cycle", cyc, mon_c);
            $display("err  cyc=%0d", cyc);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_vsync();
      VSYNC_IN = 1'b1;
      repeat (2) tick();
      VSYNC_IN = 1'b0;
      repeat (2) tick();
   endtask

   task automatic do_blank_line();
      HSYNC_IN = 1'b1;
      repeat (2) tick();
      HSYNC_IN = 1'b0;
      repeat (6) tick();
   endtask

   task automatic do_active_line(input int row, input logic [15:0] pat, input int abort_kind,
                                 input int abort_off, output int t_o);
      int  t;
      int  idx;
      wr_t w;
      HSYNC_IN = 1'b1;
      t = cyc;
      t_o = t;
      for (int k = 0; k < H_PIX; k++) begin
         if (abort_kind == AB_NONE || (FIRST_WR + CPP * k) <= abort_off) begin
            w.cyc  = t + FIRST_WR + CPP * k;
            w.addr = row * H_PIX + k;
            w.data = int'(pat[k]);
            exp_wr.push_back(w);
         end
      end
      if (abort_kind == AB_NONE && row == V_LIN - 1) exp_fd.push_back(t + FD_OFF);
      if (abort_kind == AB_VSYNC) exp_err.push_back(t + abort_off + 1);
      for (int i = 1; i <= 110; i++) begin
         tick();
         if (i == 2) HSYNC_IN = 1'b0;
         idx = (i - 41) / CPP;
         if (i >= 41 && idx < H_PIX) VIDEO_IN = pat[idx];
         else VIDEO_IN = 1'b0;
         if (abort_kind == AB_VSYNC && i == abort_off) VSYNC_IN = 1'b1;
         if (abort_kind == AB_VSYNC && i == abort_off + 2) VSYNC_IN = 1'b0;
         if (abort_kind == AB_ENABLE && i == abort_off) ENABLE = 1'b0;
         if (abort_kind == AB_RESET && i == abort_off) RESET = 1'b1;
         if (abort_kind == AB_RESET && i == abort_off + 1) begin
            RESET = 1'b0;
            check("rst_mid_wr_en", int'(WR_EN), 0);
            check("rst_mid_wr_addr", int'(WR_ADDR), 0);
            check("rst_mid_locked", int'(LOCKED), 0);
            check("rst_mid_frame_done", int'(FRAME_DONE), 0);
            check("rst_mid_sync_err", int'(SYNC_ERR), 0);
         end
      end
      ENABLE   = 1'b1;
      VIDEO_IN = 1'b0;
      repeat (4) tick();
   endtask

   task automatic run_frame(input bit with_vsync, input logic [15:0] pat, input int n_rows,
                            input int abort_kind, input int abort_off, input int pre_wait,
                            output int t_last);
      logic [15:0] lp;
      int          ab;
      if (with_vsync) do_vsync();
      repeat (pre_wait) tick();
      repeat (V_OFF) do_blank_line();
      t_last = 0;
      for (int r = 0; r < n_rows; r++) begin
         lp = pat ^ 16'(r * 4951);
         ab = (r == n_rows - 1) ? abort_kind : AB_NONE;
         do_active_line(r, lp, ab, abort_off, t_last);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t_last;
      RESET    = 1'b1;
      ENABLE   = 1'b1;
      HSYNC_IN = 1'b1;
      VSYNC_IN = 1'b1;
      VIDEO_IN = 1'b0;
      repeat (3) tick();
      check("reset_wr_en", int'(WR_EN), 0);
      check("reset_wr_addr", int'(WR_ADDR), 0);
      check("reset_wr_data", int'(WR_DATA), 0);
      check("reset_frame_done", int'(FRAME_DONE), 0);
      check("reset_locked", int'(LOCKED), 0);
      check("reset_sync_err", int'(SYNC_ERR), 0);
      RESET = 1'b0;

      // Syncs held high across reset release; only a real VSYNC transition
      // starts a frame, and the still-high HSYNC must not open a line.
      repeat (10) tick();
      VSYNC_IN = 1'b0;
      repeat (2) tick();
      do_vsync();
      repeat (60) tick();
      HSYNC_IN = 1'b0;
      repeat (3) tick();
      run_frame(1'b0, 16'hAAAA, V_LIN, AB_NONE, 0, 0, t_last);
      check("locked_after_nominal", int'(LOCKED), 1);

      // VSYNC edge in the middle of row 2.
      run_frame(1'b1, 16'h3C5A, 3, AB_VSYNC, 62, 0, t_last);
      check("locked_after_vsync_err", int'(LOCKED), 0);

      run_frame(1'b1, 16'h96E1, V_LIN, AB_NONE, 0, 0, t_last);
      check("locked_after_recovery", int'(LOCKED), 1);

      // Long pre-wait at row 0 must not time out; missing HSYNC after row 1 must.
      run_frame(1'b1, 16'h0FF0, 2, AB_NONE, 0, 250, t_last);
      exp_err.push_back(t_last + FD_OFF + TIMEOUT);
      repeat (210) tick();
      check("locked_after_timeout", int'(LOCKED), 0);

      run_frame(1'b1, 16'h5A5A, V_LIN, AB_NONE, 0, 0, t_last);
      check("locked_before_enable_drop", int'(LOCKED), 1);

      run_frame(1'b1, 16'hFFFF, 1, AB_ENABLE, 55, 0, t_last);
      check("locked_after_enable_drop", int'(LOCKED), 0);

      run_frame(1'b1, 16'h1234, 1, AB_RESET, 51, 0, t_last);

      run_frame(1'b1, 16'hC0DE, V_LIN, AB_NONE, 0, 0, t_last);
      check("locked_after_reset_recovery", int'(LOCKED), 1);

      repeat (5) tick();
      check("wr_queue_drained", exp_wr.size(), 0);
      check("frame_done_queue_drained", exp_fd.size(), 0);
      check("sync_err_queue_drained", exp_err.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/capture_controller.md
# capture_controller

Sequences capture of the HP monochrome video stream into the frame buffer. It takes the already-synchronized HSYNC/VSYNC/VIDEO signals, locks onto frame and line timing, and skips the vertical and horizontal porches. It then issues one frame-buffer write per pixel at mid-pixel sample points, and reports lock state and sync errors to the VGA output side.

## Interface
- H_PIXELS, 512: active pixels per line
- V_LINES, 384: active lines per frame
- V_OFFSET, 16: lines skipped after VSYNC before the first active line
- H_OFFSET, 40: CLK cycles from the HSYNC rising edge to the first pixel (≥1)
- CLKS_PER_PIXEL, 4: CLK cycles per source pixel (≥2)
- LINE_TIMEOUT, 4096: maximum CLK cycles to wait for an HSYNC between active lines
- ADDR_WIDTH, 18: frame-buffer address width (must hold H_PIXELS*V_LINES)

Ports:
- CLK  in  1  system clock; the only clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  capture enable
- HSYNC_IN  in  1  synchronized HSYNC, active-high
- VSYNC_IN  in  1  synchronized VSYNC, active-high
- VIDEO_IN  in  1  synchronized video level
- WR_EN  out  1  one-cycle frame-buffer write strobe
- WR_ADDR  out  ADDR_WIDTH  write address, row-major
- WR_DATA  out  1  sampled pixel value
- FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is written
- LOCKED  out  1  high after a complete error-free frame
- SYNC_ERR  out  1  one-cycle pulse on any timing violation

## Operation
- Edge detection:
  - Rising edge = input high AND previous-cycle register low.
  - Previous-cycle registers reset to 1, so an input held high through reset produces no edge.
- FSM states: IDLE, WAIT_VSYNC, WAIT_HSYNC, H_PORCH, SAMPLE.
- IDLE: go to WAIT_VSYNC when ENABLE=1.
- WAIT_VSYNC: on a VSYNC edge, go to WAIT_HSYNC and clear line_cnt, row, WR_ADDR counter and timeout counter.
- WAIT_HSYNC, on an HSYNC edge:
  - If line_cnt < V_OFFSET: increment line_cnt and stay.
  - Otherwise: go to H_PORCH and clear clk_cnt.
  - The timeout counter runs only once row > 0. Reaching LINE_TIMEOUT gives SYNC_ERR, LOCKED←0, WAIT_VSYNC.
- H_PORCH: after H_OFFSET cycles, go to SAMPLE with phase=0 and px=0.
- SAMPLE:
  - phase counts 0..CLKS_PER_PIXEL-1 and wraps.
  - At phase = CLKS_PER_PIXEL/2, VIDEO_IN is registered to WR_DATA, WR_EN pulses the next cycle, and the address counter then increments.
  - After the write with px = H_PIXELS-1:
    - If row = V_LINES-1: FRAME_DONE pulse, LOCKED←1, WAIT_VSYNC.
    - Otherwise: row++, timeout cleared, WAIT_HSYNC.
- Violations (all give SYNC_ERR pulse, LOCKED←0, WAIT_VSYNC with counters cleared):
  - HSYNC edge during H_PORCH or SAMPLE.
  - VSYNC edge in WAIT_HSYNC, H_PORCH or SAMPLE.
- Simultaneous HSYNC and VSYNC edges: VSYNC handling wins.
- ENABLE=0 in any state: IDLE next cycle; no further WR_EN; LOCKED←0; no SYNC_ERR.
- WR_ADDR is a running counter. No multiplier; it never exceeds H_PIXELS*V_LINES-1.

## Timing
- Reset: state IDLE; WR_EN, WR_ADDR, WR_DATA, FRAME_DONE, LOCKED, SYNC_ERR all 0; counters 0.
- All outputs are registered.
- HSYNC edge visible in cycle t (active line): H_PORCH covers t+1..t+H_OFFSET, and SAMPLE phase 0 is at t+H_OFFSET+1.
- Pixel k is sampled at t+H_OFFSET+1+CLKS_PER_PIXEL/2+k·CLKS_PER_PIXEL. Its WR_EN is one cycle later. With defaults: pixel 0 WR_EN at t+44, pixel 511 at t+2088.
- FRAME_DONE is asserted the cycle after the last WR_EN.
- SYNC_ERR is asserted the cycle after the offending edge or timeout.
- RESET mid-line: the next cycle is IDLE with all outputs 0; the partial line is abandoned.

## Structure
- capture_pkg holds the state enum and default timing constants; the VGA output side shares them.
- One sub-module, sync_edge_detect (rising-edge detector with reset-to-1 register), instantiated for HSYNC and VSYNC.

## Test plan
- Nominal frame (defaults, ENABLE=1, VSYNC, then 16+384 HSYNCs, VIDEO alternating per pixel) -> 196608 WR_EN pulses; addresses 0..196607 in order; data alternates 0/1; one FRAME_DONE; LOCKED=1 after.
- Single-line timing (HSYNC edge at cycle t) -> first WR_EN at t+44, 4-cycle spacing, last at t+2088.
- HSYNC held high through reset release -> no edge; FSM stays in WAIT_HSYNC until a genuine low-to-high transition.
- VSYNC edge mid-line at row 10 -> SYNC_ERR one cycle later, LOCKED=0, no WR_EN until the next frame, which restarts at WR_ADDR 0.
- HSYNC missing after row 5 -> SYNC_ERR exactly 4096 cycles after entering WAIT_HSYNC.
- ENABLE dropped during SAMPLE, and RESET asserted during SAMPLE -> no WR_EN from the next cycle; state IDLE; no SYNC_ERR.
